// File: rtl/mem_pkg.sv
// Shared definitions for the byte-memory controller.
// ADDR_W    : byte address width (bank bits on top, offset below)
// DATA_W    : memory data width (one byte per access)
// BANK_BITS : number of upper address bits that select the bank
// size_e    : request size encoding (byte / little-endian halfword)
// state_e   : controller FSM states
package mem_pkg;

   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BANK_BITS = 2;

   typedef enum logic {
      SZ_BYTE = 1'b0,
      SZ_HALF = 1'b1
   } size_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      CAP  = 3'd3,
      RSP  = 3'd4
   } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: host-request to byte-memory controller.
// Accepts one byte or halfword (little-endian) request at a time and turns it
// into one or two single-byte accesses on the memory port, then returns a
// response that is held until the host takes it.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only when idle)
//   req_we, req_size, req_addr,  request: write enable, size, byte address,
//   req_wdata                    write data (byte writes use [7:0])
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata                    read data, zero for writes
//   mem_we, mem_re               one-cycle memory strobes, never both high
//   mem_addr, mem_wdata          memory address/data, held between accesses
//   mem_rdata                    memory read data, valid the cycle after mem_re
module mem_ctrl
   import mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic                req_size,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2*DATA_W-1:0] rsp_rdata,
   output logic                mem_we,
   output logic                mem_re,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_e              state_q,    state_d;
   logic                we_q,       we_d;
   size_e               size_q,     size_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   // Only the upper byte is needed after accept; the lower byte goes
   // straight into the memory data register.
   logic [DATA_W-1:0]   wdata_hi_q, wdata_hi_d;
   logic [2*DATA_W-1:0] rdata_q,    rdata_d;
   logic [ADDR_W-1:0]   maddr_q,    maddr_d;
   logic [DATA_W-1:0]   mwdata_q,   mwdata_d;

   logic in_access;

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_hi_d = wdata_hi_q;
      rdata_d    = rdata_q;
      maddr_d    = maddr_q;
      mwdata_d   = mwdata_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               size_d     = size_e'(req_size);
               addr_d     = req_addr;
               wdata_hi_d = req_wdata[2*DATA_W-1:DATA_W];
               rdata_d    = '0;
               // Memory address/data are registered, so load them for ACC0 now.
               maddr_d    = req_addr;
               mwdata_d   = req_wdata[DATA_W-1:0];
               state_d    = ACC0;
            end
         end
         ACC0: begin
            if (size_q == SZ_HALF) begin
               // 12-bit add wraps 0xFFF -> 0x000 and crosses banks freely.
               maddr_d  = addr_q + ADDR_W'(1);
               mwdata_d = wdata_hi_q;
               state_d  = ACC1;
            end else if (!we_q) begin
               state_d = CAP;
            end else begin
               state_d = RSP;
            end
         end
         ACC1: begin
            // mem_rdata here is the byte fetched in ACC0.
            if (!we_q) begin
               rdata_d[DATA_W-1:0] = mem_rdata;
            end
            state_d = we_q ? RSP : CAP;
         end
         CAP: begin
            if (size_q == SZ_HALF) begin
               rdata_d[2*DATA_W-1:DATA_W] = mem_rdata;
            end else begin
               rdata_d = {{DATA_W{1'b0}}, mem_rdata};
            end
            state_d = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         addr_q     <= '0;
         wdata_hi_q <= '0;
         rdata_q    <= '0;
         maddr_q    <= '0;
         mwdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_hi_q <= wdata_hi_d;
         rdata_q    <= rdata_d;
         maddr_q    <= maddr_d;
         mwdata_q   <= mwdata_d;
      end
   end

   // Strobes decode straight from state so a reset drops them immediately.
   assign in_access = (state_q == ACC0) || (state_q == ACC1);
   assign mem_we    = in_access &&  we_q;
   assign mem_re    = in_access && !we_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RSP);
   assign rsp_rdata = rdata_q;

endmodule
